// File: rtl/sram_ctrl_pkg.sv
// Shared geometry and request type for controllers that front a 1RW+1R OpenRAM macro.
package sram_ctrl_pkg;

    localparam int SRAM_ADDR_W  = 8;
    localparam int SRAM_DATA_W  = 32;
    localparam int SRAM_WMASK_W = 4;
    localparam int SRAM_DEPTH   = 256;

    typedef struct packed {
        logic                    we;
        logic [SRAM_WMASK_W-1:0] wmask;
        logic [SRAM_ADDR_W-1:0]  addr;
        logic [SRAM_DATA_W-1:0]  wdata;
    } sram_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search starts at the pointer, and the pointer moves past the grantee on advance.
module rr_arbiter
    import sram_ctrl_pkg::*;
#(
    parameter  int N  = 2,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [N-1:0]  req_i,
    input  logic          advance_i,
    output logic [N-1:0]  gnt_o,
    output logic [PW-1:0] ptr_o
);

    logic [PW-1:0] ptr_q, ptr_d, win_idx;
    logic          found;
    int            idx;

    always_comb begin
        gnt_o   = '0;
        found   = 1'b0;
        win_idx = '0;
        idx     = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr_q) + i) % N;
            if (!found && req_i[PW'(idx)]) begin
                gnt_o[PW'(idx)] = 1'b1;
                win_idx         = PW'(idx);
                found           = 1'b1;
            end
        end
    end

    // Pointer wraps explicitly so non-power-of-two N stays in range.
    always_comb begin
        ptr_d = ptr_q;
        if (advance_i && found) begin
            ptr_d = (int'(win_idx) == N - 1) ? '0 : win_idx + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/sram_1rw1r_arbiter.sv
// Shares a 1RW+1R SRAM macro between NUM_REQ round-robin requesters on port 0 and one reader on port 1.
module sram_1rw1r_arbiter
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = SRAM_ADDR_W,
    parameter int DATA_WIDTH = SRAM_DATA_W,
    parameter int NUM_WMASKS = SRAM_WMASK_W,
    parameter int NUM_REQ    = 2
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NUM_REQ-1:0]             req_valid_i,
    output logic [NUM_REQ-1:0]             req_ready_o,
    input  logic [NUM_REQ-1:0]             req_we_i,
    input  logic [NUM_REQ*NUM_WMASKS-1:0]  req_wmask_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata_i,
    output logic [NUM_REQ-1:0]             rsp_valid_o,
    output logic [DATA_WIDTH-1:0]          rsp_rdata_o,
    input  logic                           rd_valid_i,
    output logic                           rd_ready_o,
    input  logic [ADDR_WIDTH-1:0]          rd_addr_i,
    output logic                           rd_rsp_valid_o,
    output logic [DATA_WIDTH-1:0]          rd_rdata_o,
    output logic                           sram_csb0_o,
    output logic                           sram_web0_o,
    output logic [NUM_WMASKS-1:0]          sram_wmask0_o,
    output logic [ADDR_WIDTH-1:0]          sram_addr0_o,
    output logic [DATA_WIDTH-1:0]          sram_din0_o,
    input  logic [DATA_WIDTH-1:0]          sram_dout0_i,
    output logic                           sram_csb1_o,
    output logic [ADDR_WIDTH-1:0]          sram_addr1_o,
    input  logic [DATA_WIDTH-1:0]          sram_dout1_i
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]    req_valid, gnt;
    logic [PW-1:0]         rr_ptr_unused;
    sram_req_t             win;
    logic                  p0_fire, collision, rd_fire;

    logic [NUM_REQ-1:0]    s1_gnt_q, rsp_valid_q;
    logic                  s1_we_q, s1_rd_q, rd_rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d, rd_rdata_q, rd_rdata_d;

    // Holding requests off during reset keeps ready low and the pointer untouched.
    assign req_valid = rst_i ? '0 : req_valid_i;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     (req_valid),
        .advance_i (p0_fire),
        .gnt_o     (gnt),
        .ptr_o     (rr_ptr_unused)
    );

    always_comb begin
        win = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                win.we    = req_we_i[i];
                win.wmask = req_wmask_i[i*NUM_WMASKS +: NUM_WMASKS];
                win.addr  = req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                win.wdata = req_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign p0_fire       = |gnt;
    assign req_ready_o   = gnt;
    assign sram_csb0_o   = ~p0_fire;
    assign sram_web0_o   = ~(p0_fire & win.we);
    assign sram_wmask0_o = win.wmask;
    assign sram_addr0_o  = win.addr;
    assign sram_din0_o   = win.wdata;

    // Port 1 must not read a word that port 0 is writing in the same cycle.
    assign collision    = rd_valid_i & p0_fire & win.we & (rd_addr_i == win.addr);
    assign rd_ready_o   = ~rst_i & ~collision;
    assign rd_fire      = rd_valid_i & rd_ready_o;
    assign sram_csb1_o  = ~rd_fire;
    assign sram_addr1_o = rd_fire ? rd_addr_i : '0;

    always_comb begin
        rsp_rdata_d = ((|s1_gnt_q) && !s1_we_q) ? sram_dout0_i : '0;
        rd_rdata_d  = s1_rd_q ? sram_dout1_i : '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_gnt_q       <= '0;
            s1_we_q        <= 1'b0;
            s1_rd_q        <= 1'b0;
            rsp_valid_q    <= '0;
            rsp_rdata_q    <= '0;
            rd_rsp_valid_q <= 1'b0;
            rd_rdata_q     <= '0;
        end else begin
            s1_gnt_q       <= gnt;
            s1_we_q        <= win.we;
            s1_rd_q        <= rd_fire;
            rsp_valid_q    <= s1_gnt_q;
            rsp_rdata_q    <= rsp_rdata_d;
            rd_rsp_valid_q <= s1_rd_q;
            rd_rdata_q     <= rd_rdata_d;
        end
    end

    assign rsp_valid_o    = rsp_valid_q;
    assign rsp_rdata_o    = rsp_rdata_q;
    assign rd_rsp_valid_o = rd_rsp_valid_q;
    assign rd_rdata_o     = rd_rdata_q;

endmodule

// File: doc/sram_1rw1r_arbiter.md
# sram_1rw1r_arbiter

Controller that shares a 1RW+1R OpenRAM SRAM macro (e.g. `sky130_sram_1kbyte_1rw1r_32x256_8`) between `NUM_REQ` read/write requesters on port 0 and one read-only requester on port 1. It arbitrates port 0 round-robin and drives the macro's active-low controls. It captures macro read data into registered responses and stalls port-1 reads that collide with a same-cycle port-0 write to the same address. It sits between bus adapters/cores and the macro instance.

## Interface
- `ADDR_WIDTH`, 8: word address width.
- `DATA_WIDTH`, 32: data width.
- `NUM_WMASKS`, 4: byte-lane mask width (`DATA_WIDTH/8`).
- `NUM_REQ`, 2: number of port-0 requesters (≥1).
- `clk_i`  in  1: single clock; the macro's `clk0`/`clk1` are tied to it.
- `rst_i`  in  1: reset, synchronous, active-high.
- `req_valid_i`  in  `NUM_REQ`: per-requester request valid.
- `req_ready_o`  out  `NUM_REQ`: one-hot grant; the handshake completes when valid&ready.
- `req_we_i`  in  `NUM_REQ`: 1 = write, 0 = read.
- `req_wmask_i`  in  `NUM_REQ*NUM_WMASKS`: packed byte masks.
- `req_addr_i`  in  `NUM_REQ*ADDR_WIDTH`: packed addresses.
- `req_wdata_i`  in  `NUM_REQ*DATA_WIDTH`: packed write data.
- `rsp_valid_o`  out  `NUM_REQ`: one-cycle response pulse; reads and writes both respond.
- `rsp_rdata_o`  out  `DATA_WIDTH`: read data, shared; qualified by `rsp_valid_o`.
- `rd_valid_i`, `rd_ready_o`, `rd_addr_i`(`ADDR_WIDTH`): port-1 read request handshake.
- `rd_rsp_valid_o`  out  1; `rd_rdata_o`  out  `DATA_WIDTH`: port-1 response.
- `sram_csb0_o`, `sram_web0_o`  out  1: active-low chip select and write enable to the macro.
- `sram_wmask0_o`, `sram_addr0_o`, `sram_din0_o`  out: port-0 macro inputs.
- `sram_dout0_i`  in  `DATA_WIDTH`: port-0 macro output.
- `sram_csb1_o`  out  1; `sram_addr1_o`  out  `ADDR_WIDTH`; `sram_dout1_i`  in  `DATA_WIDTH`: port-1 macro pins.

## Operation
- **Port-0 arbitration (round-robin):**
  - Search starts at pointer `rr_q`.
  - The first requester with valid set gets `req_ready_o`.
  - On a handshake, `rr_q` becomes (grantee+1) mod `NUM_REQ`.
  - With no request, `rr_q` holds.
  - One grant per cycle; a lone requester is granted every cycle.
- **Port-0 macro drive (combinational from the winner):**
  - `sram_csb0_o`=0, `sram_web0_o`=~we, and mask/addr/din from the winner.
  - Idle: `csb0`=1, `web0`=1, mask/addr/din=0.
- **Port-0 response pipeline:** two registered stages carry one-hot grantee and we (`s1`, `s2`).
  - Stage s2 drives `rsp_valid_o`.
  - `rsp_rdata_o` is `sram_dout0_i` captured at the edge ending cycle t+1 for reads; 0 for writes.
- **Port 1:**
  - `rd_ready_o` = ~collision.
  - collision = `rd_valid_i` & port-0 write handshake this cycle & `rd_addr_i`==winner addr.
  - On a port-1 handshake: `csb1`=0, `addr1`=`rd_addr_i`; otherwise `csb1`=1, `addr1`=0.
  - The same two-stage pipeline produces `rd_rsp_valid_o`/`rd_rdata_o` from `sram_dout1_i`.
  - A port-0 *read* to the same address never stalls port 1.
- **wmask:** a write with wmask=0 is still a write: no bytes change, and it still gets a response.
- **No response backpressure:** requesters must accept `rsp_valid_o` the cycle it is high.

## Timing
- **Reset (synchronous, active-high):**
  - `rr_q`=0 and all pipeline valids cleared.
  - `rsp_valid_o`=0, `rd_rsp_valid_o`=0, `rsp_rdata_o`=0, `rd_rdata_o`=0.
  - `sram_csb0_o`=1, `sram_web0_o`=1, `sram_csb1_o`=1.
  - `req_ready_o`=0 and `rd_ready_o`=0 while `rst_i` is high.
- **Reset mid-operation:** in-flight responses are dropped (never emitted), and the pointer returns to 0.
- **Latency:** handshake in cycle t → macro samples at the end of cycle t → data valid before the end of t+1 → `rsp_valid_o` high in cycle t+2. Both ports behave identically.
- **Throughput:** one port-0 and one port-1 access per cycle, fully pipelined.
- **Write-then-read:** a write in cycle t is visible to a read of either port handshaked in t+1 or later.
- **Collision stall:** lasts exactly the cycles in which the colliding write is granted. `rd_valid_i` must stay asserted with stable `rd_addr_i` until `rd_ready_o`.
- **Pointer wrap:** `NUM_REQ-1` → 0.

## Structure
- **`sram_ctrl_pkg`:** macro geometry constants (`SRAM_ADDR_W`=8, `SRAM_DATA_W`=32, `SRAM_WMASK_W`=4, `SRAM_DEPTH`=256) and a `sram_req_t` struct (we, wmask, addr, wdata).
- **`rr_arbiter`:** one sub-module, parameter N, with inputs req and advance, outputs one-hot gnt and pointer state. The parent holds the datapath and pipelines.

## Test plan
- **Single read after write:** requester 0 writes addr 0x10 with data 0xDEADBEEF, mask 0xF; then reads 0x10 → `rsp_valid_o[0]` in t+2 with `rsp_rdata_o`=0xDEADBEEF.
- **Byte mask:** write 0x11223344 to addr 0x20; then write 0xAABBCCDD with mask 0b0101; read → 0x11BB33DD.
- **Round-robin fairness:** both requesters hold valid for 6 cycles → grants alternate 0,1,0,1,0,1, and each gets 3 responses in order.
- **Collision stall:** same cycle, req0 writes 0x05 and port 1 reads 0x05 → `rd_ready_o`=0 that cycle, granted next cycle, `rd_rdata_o` = new data. A port-1 read of 0x06 in that same cycle is not stalled.
- **Back-to-back pipeline:** reads of addresses 0..7 on consecutive cycles → 8 consecutive `rsp_valid_o` pulses carrying the preloaded values in order.
- **Reset mid-flight:** assert `rst_i` the cycle after a read handshake → no response emitted, `sram_csb0_o`=1, and the pointer is 0 after reset.
